// File: rtl/self_attention_pkg.sv
// Shared types and defaults for the self-attention head control blocks.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package self_attention_pkg;

    // Qn x KnT tile sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        ACC_CLR  = 3'd2,
        FEED     = 3'd3,
        WAIT_SYS = 3'd4,
        WAIT_ACC = 3'd5,
        DRAIN    = 3'd6,
        DONE     = 3'd7
    } qk_seq_state_e;

    // Default tiling of one head pass
    localparam int QK_INNER_TILES = 4;
    localparam int QK_OUT_TILES   = 8;

    // Counter width for n values, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qk_tile_sequencer.sv
// Sequences Qn x KnT: clear, per-tile accumulate over INNER_TILES operand pairs, offer tile to bridge.
// Latency: min 2 + INNER_TILES*2 cycles per output tile; all outputs Moore (registered state only).
// Backpressure: holds in FEED until in_valid, in WAIT_SYS/WAIT_ACC until datapath done, in DRAIN until bridge_ready.
module qk_tile_sequencer
    import self_attention_pkg::*;
#(
    parameter int  INNER_TILES = QK_INNER_TILES,
    parameter int  OUT_TILES   = QK_OUT_TILES,
    localparam int IW          = clog2_min1(INNER_TILES),
    localparam int TW          = clog2_min1(OUT_TILES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sys_finish,
    input  logic          acc_done,
    input  logic          bridge_ready,
    output logic          en_Qn_KnT,
    output logic          rst_n_Qn_KnT,
    output logic          reset_acc_Qn_KnT,
    output logic          out_valid_Qn_KnT,
    output logic [IW-1:0] inner_idx,
    output logic [TW-1:0] tile_idx,
    output logic          busy,
    output logic          done
);

    localparam logic [IW-1:0] INNER_LAST = IW'(INNER_TILES - 1);
    localparam logic [TW-1:0] TILE_LAST  = TW'(OUT_TILES - 1);

    qk_seq_state_e state;
    qk_seq_state_e state_nxt;
    logic [IW-1:0] inner_nxt;
    logic [TW-1:0] tile_nxt;
    // Remembers an acc_done that arrived before the last systolic step finished
    logic          acc_flag;
    logic          acc_flag_nxt;

    // State, counters and early-completion flag; synchronous reset aborts any pass
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            inner_idx <= '0;
            tile_idx  <= '0;
            acc_flag  <= 1'b0;
        end else begin
            state     <= state_nxt;
            inner_idx <= inner_nxt;
            tile_idx  <= tile_nxt;
            acc_flag  <= acc_flag_nxt;
        end
    end

    // Next-state/counter logic and Moore output decode from the registered state
    always_comb begin
        state_nxt        = state;
        inner_nxt        = inner_idx;
        tile_nxt         = tile_idx;
        acc_flag_nxt     = acc_flag;
        in_ready         = 1'b0;
        en_Qn_KnT        = 1'b0;
        rst_n_Qn_KnT     = 1'b1;
        reset_acc_Qn_KnT = 1'b0;
        out_valid_Qn_KnT = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                rst_n_Qn_KnT = 1'b0;
                inner_nxt    = '0;
                tile_nxt     = '0;
                acc_flag_nxt = 1'b0;
                state_nxt    = ACC_CLR;
            end
            ACC_CLR: begin
                reset_acc_Qn_KnT = 1'b1;
                inner_nxt        = '0;
                acc_flag_nxt     = 1'b0;
                state_nxt        = FEED;
            end
            FEED: begin
                // in_ready is high throughout FEED, so in_valid alone completes the handshake
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = WAIT_SYS;
                end
            end
            WAIT_SYS: begin
                en_Qn_KnT = 1'b1;
                if (acc_done) begin
                    acc_flag_nxt = 1'b1;
                end
                if (sys_finish) begin
                    if (inner_idx != INNER_LAST) begin
                        inner_nxt = inner_idx + 1'b1;
                        state_nxt = FEED;
                    end else if (acc_done) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = WAIT_ACC;
                    end
                end
            end
            WAIT_ACC: begin
                if (acc_done || acc_flag) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid_Qn_KnT = 1'b1;
                if (bridge_ready) begin
                    if (tile_idx != TILE_LAST) begin
                        tile_nxt  = tile_idx + 1'b1;
                        state_nxt = ACC_CLR;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done         = 1'b1;
                inner_nxt    = '0;
                tile_nxt     = '0;
                acc_flag_nxt = 1'b0;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qk_tile_sequencer.sv
// Bench for qk_tile_sequencer: datapath/buffer responder plus scoreboard of feed, drain and done events.
// Latency: n/a (cycle-stepped from a single process, driving and sampling on the falling edge).
// Backpressure: in_valid and bridge_ready stalls are injected per pass.
module tb_qk_tile_sequencer;

    localparam int INNER  = 4;
    localparam int OUT    = 2;
    localparam int IW     = 2;
    localparam int TW     = 1;
    localparam int BUDGET = 3000;
    localparam logic [IW-1:0] INNER_LAST = IW'(INNER - 1);
    localparam int NONE   = 'h0FFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b1;
    logic          in_valid = 1'b0;
    logic          sys_finish = 1'b0;
    logic          acc_done = 1'b0;
    logic          bridge_ready = 1'b0;
    logic          in_ready, en_Qn_KnT, rst_n_Qn_KnT, reset_acc_Qn_KnT, out_valid_Qn_KnT;
    logic          busy, done;
    logic [IW-1:0] inner_idx;
    logic [TW-1:0] tile_idx;

    always #5 clk = ~clk;

    qk_tile_sequencer #(.INNER_TILES(INNER), .OUT_TILES(OUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .sys_finish       (sys_finish),
        .acc_done         (acc_done),
        .bridge_ready     (bridge_ready),
        .en_Qn_KnT        (en_Qn_KnT),
        .rst_n_Qn_KnT     (rst_n_Qn_KnT),
        .reset_acc_Qn_KnT (reset_acc_Qn_KnT),
        .out_valid_Qn_KnT (out_valid_Qn_KnT),
        .inner_idx        (inner_idx),
        .tile_idx         (tile_idx),
        .busy             (busy),
        .done             (done)
    );

    int checks = 0;
    int failures = 0;

    // responder knobs and state
    int sys_lat = 3, acc_lat = 2, iv_stall = 0, br_stall = 0;
    bit acc_early = 1'b0;
    int en_cnt = 0, acc_cnt = 0, cyc = 0;
    bit en_prev = 1'b0, ov_prev = 1'b0;

    // per-pass statistics
    int n_clear, n_rst_acc, n_en_rise, n_en_cyc, n_in_rdy, n_out_vld, n_wait_acc, n_busy, n_done;

    // scoreboard: feed entries are tile*16+inner, drain entries are tile, lat entries are cycles
    int feed_q[$];
    int drain_q[$];
    int lat_q[$];
    int done_q[$];
    int fin_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: at the falling edge drive the datapath/buffer responses, then score the outputs
    task automatic tick();
        bit last_step;
        int e;
        @(negedge clk);
        cyc++;

        in_valid = 1'b1;
        if (in_ready === 1'b1 && iv_stall > 0) begin
            in_valid = 1'b0;
            iv_stall--;
        end
        bridge_ready = 1'b1;
        if (out_valid_Qn_KnT === 1'b1 && br_stall > 0) begin
            bridge_ready = 1'b0;
            br_stall--;
        end
        acc_done = 1'b0;
        if (acc_cnt > 0) begin
            acc_cnt--;
            if (acc_cnt == 0) acc_done = 1'b1;
        end
        if (en_Qn_KnT === 1'b1) begin
            en_cnt++;
            sys_finish = (en_cnt == sys_lat);
            last_step  = (inner_idx == INNER_LAST);
            if (last_step && acc_early && tile_idx == '0) begin
                if (en_cnt == 1) acc_done = 1'b1;
                if (sys_finish) begin
                    fin_cyc = cyc;
                    lat_q.push_back(2);
                end
            end else if (last_step && sys_finish) begin
                fin_cyc = cyc;
                lat_q.push_back(acc_lat + 1);
                if (acc_lat == 0) acc_done = 1'b1;
                else acc_cnt = acc_lat;
            end
        end else begin
            en_cnt = 0;
            sys_finish = ($urandom_range(0, 1) == 1);
        end
        if (!acc_done && (in_ready === 1'b1 || out_valid_Qn_KnT === 1'b1 || busy === 1'b0))
            acc_done = ($urandom_range(0, 1) == 1);

        if (rst_n_Qn_KnT === 1'b0) n_clear++;
        if (reset_acc_Qn_KnT === 1'b1) n_rst_acc++;
        if (en_Qn_KnT === 1'b1) n_en_cyc++;
        if (en_Qn_KnT === 1'b1 && !en_prev) n_en_rise++;
        if (busy === 1'b1) n_busy++;
        if (busy === 1'b1 && in_ready === 1'b0 && en_Qn_KnT === 1'b0 && rst_n_Qn_KnT === 1'b1 &&
            reset_acc_Qn_KnT === 1'b0 && out_valid_Qn_KnT === 1'b0 && done === 1'b0) n_wait_acc++;

        if (in_ready === 1'b1) begin
            n_in_rdy++;
            if (in_valid) begin
                if (feed_q.size() > 0) e = feed_q.pop_front(); else e = NONE;
                chk("feed_tile", 32'(tile_idx), e / 16);
                chk("feed_inner", 32'(inner_idx), e % 16);
            end else begin
                e = (feed_q.size() > 0) ? feed_q[0] : NONE;
                chk("feed_hold_inner", 32'(inner_idx), e % 16);
                chk("feed_hold_en", 32'(en_Qn_KnT), 0);
            end
        end
        if (out_valid_Qn_KnT === 1'b1) begin
            n_out_vld++;
            if (!ov_prev) begin
                if (lat_q.size() > 0) e = lat_q.pop_front(); else e = NONE;
                chk("drain_latency", cyc - fin_cyc, e);
            end
            if (drain_q.size() > 0) e = drain_q[0]; else e = NONE;
            chk("drain_tile", 32'(tile_idx), e);
            if (bridge_ready && drain_q.size() > 0) void'(drain_q.pop_front());
        end
        if (done === 1'b1) begin
            n_done++;
            chk("done_expected", done_q.size(), 1);
            if (done_q.size() > 0) void'(done_q.pop_front());
        end
        en_prev = (en_Qn_KnT === 1'b1);
        ov_prev = (out_valid_Qn_KnT === 1'b1);
    endtask

    task automatic clear_stats();
        n_clear = 0; n_rst_acc = 0; n_en_rise = 0; n_en_cyc = 0; n_in_rdy = 0;
        n_out_vld = 0; n_wait_acc = 0; n_busy = 0; n_done = 0;
    endtask

    task automatic flush();
        feed_q.delete(); drain_q.delete(); lat_q.delete(); done_q.delete();
        acc_cnt = 0; iv_stall = 0; br_stall = 0;
    endtask

    // Arm the responder, push the expected event stream, start a pass and score it
    task automatic begin_pass(input int s_lat, input int a_lat, input bit early, input int iv_st, input int br_st);
        sys_lat = s_lat; acc_lat = a_lat; acc_early = early; iv_stall = iv_st; br_stall = br_st;
        clear_stats();
        for (int t = 0; t < OUT; t++) begin
            for (int i = 0; i < INNER; i++) feed_q.push_back(t * 16 + i);
            drain_q.push_back(t);
        end
        done_q.push_back(1);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_pass(input string name, input int s_lat, input int a_lat, input bit early,
                            input int iv_st, input int br_st);
        int exp_wait;
        int exp_busy;
        begin_pass(s_lat, a_lat, early, iv_st, br_st);
        for (int c = 0; c < BUDGET && n_done == 0; c++) tick();
        tick();
        tick();
        exp_wait = early ? 1 + (OUT - 1) * a_lat : OUT * a_lat;
        exp_busy = 2 + OUT * (2 + INNER * (1 + s_lat)) + exp_wait + iv_st + br_st;
        chk({name, "_done"}, n_done, 1);
        chk({name, "_clear"}, n_clear, 1);
        chk({name, "_reset_acc"}, n_rst_acc, OUT);
        chk({name, "_en_bursts"}, n_en_rise, OUT * INNER);
        chk({name, "_en_cycles"}, n_en_cyc, OUT * INNER * s_lat);
        chk({name, "_in_ready"}, n_in_rdy, OUT * INNER + iv_st);
        chk({name, "_out_valid"}, n_out_vld, OUT + br_st);
        chk({name, "_wait_acc"}, n_wait_acc, exp_wait);
        chk({name, "_busy_cycles"}, n_busy, exp_busy);
        chk({name, "_left"}, feed_q.size() + drain_q.size() + lat_q.size() + done_q.size(), 0);
        chk({name, "_idle"}, 32'(busy), 0);
        if (n_done == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        flush();
    endtask

    initial begin
        // reset held with start high: IDLE, all outputs at reset values
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_outputs", {25'd0, in_ready, en_Qn_KnT, rst_n_Qn_KnT, reset_acc_Qn_KnT,
                                out_valid_Qn_KnT, busy, done}, 32'b0010000);
            chk("rst_counters", {30'd0, tile_idx, inner_idx}, 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_idle", 32'(busy), 0);
        end

        run_pass("nominal", 3, 2, 1'b0, 0, 0);
        run_pass("drain_stall", 1, 1, 1'b0, 0, 5);
        run_pass("feed_stall", 3, 2, 1'b0, 10, 0);
        run_pass("same_cycle", 3, 0, 1'b0, 0, 0);
        run_pass("acc_early", 3, 2, 1'b1, 0, 0);

        // reset in WAIT_SYS of tile 1, with start pulses while busy
        begin_pass(3, 2, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (en_Qn_KnT === 1'b1 && tile_idx == 1'b1) break;
            tick();
            if (c == 6) start = 1'b1;
            if (c == 7) start = 1'b0;
        end
        chk("abort_reached_tile1", 32'(en_Qn_KnT === 1'b1 && tile_idx == 1'b1), 1);
        chk("abort_feed_progress", feed_q.size(), OUT * INNER - INNER - 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_outputs", {27'd0, en_Qn_KnT, rst_n_Qn_KnT, out_valid_Qn_KnT, in_ready, done}, 32'b01000);
        chk("abort_counters", {30'd0, tile_idx, inner_idx}, 0);
        flush();
        for (int k = 0; k < 5; k++) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_still_idle", 32'(busy), 0);
        run_pass("fresh", 3, 2, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
